vector_mem_responder: RTL and testbench

//   Memory-side responder for the vector unit's element-serial load/store port
//   (mem_addr/mem_read/mem_write/data). Holds a word-addressed data store

---
 rtl/vector_mem_responder.sv | 214 +++++++++++++++++++++
 tb/tb_vector_mem_responder.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_mem_responder.sv
// ---------------------------------------------------------------------------
// vector_mem_responder
//
// Memory-side responder for the vector unit's element-serial load/store
// port. Holds a word-addressed data store that answers vector loads
// combinationally in the same cycle and commits vector stores on the rising
// clock edge. A secondary host port preloads and inspects the store; it is
// served only in cycles where the vector side is idle, so it never stalls
// the vector unit. The block also flags illegal vector requests, counts
// legal reads/writes and tracks the length of the current sequential burst.
//
// Ports
//   clk         single clock, all state changes on the rising edge
//   rst         synchronous active-high reset (memory contents preserved)
//   mem_addr    byte address from the vector unit
//   mem_read    vector load element request (level)
//   mem_write   vector store element request (level)
//   mem_wdata   store data from the vector unit
//   mem_rdata   load data to the vector unit, combinational, 0 if not legal
//   mem_err     combinational pulse: current vector request is illegal
//   err_sticky  set by any mem_err, cleared only by rst
//   host_req    host access request, held high until host_ack
//   host_we     1 = host write, 0 = host read
//   host_addr   host word index
//   host_wdata  host write data
//   host_rdata  registered host read data
//   host_ack    one-cycle host completion pulse
//   rd_count    saturating count of legal vector reads
//   wr_count    saturating count of legal vector writes
//   burst_len   saturating length of the current sequential access run
// ---------------------------------------------------------------------------
module vector_mem_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256,
    parameter int ADDR_BITS  = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           mem_addr,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_err,
    output logic                  err_sticky,
    input  logic                  host_req,
    input  logic                  host_we,
    input  logic [ADDR_BITS-1:0]  host_addr,
    input  logic [DATA_WIDTH-1:0] host_wdata,
    output logic [DATA_WIDTH-1:0] host_rdata,
    output logic                  host_ack,
    output logic [CNT_WIDTH-1:0]  rd_count,
    output logic [CNT_WIDTH-1:0]  wr_count,
    output logic [CNT_WIDTH-1:0]  burst_len
);

    localparam int                   BYTES      = DATA_WIDTH / 8;
    localparam int                   BYTE_SHIFT = $clog2(BYTES);
    localparam logic [31:0]          ALIGN_MASK = 32'(BYTES - 1);
    localparam logic [31:0]          STRIDE     = 32'(BYTES);
    localparam logic [31:0]          DEPTH_W    = 32'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;

    typedef enum logic [1:0] {
        H_IDLE,
        H_WAIT,
        H_ACK
    } host_state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [31:0]          idx;
    logic [ADDR_BITS-1:0] vec_idx;
    logic                 vec_busy;
    logic                 vec_legal;
    logic                 rd_ok;
    logic                 wr_ok;
    logic                 host_in_range;

    host_state_t state;
    host_state_t next_state;
    logic        host_go;

    logic        prev_busy;
    logic        prev_rd;
    logic        prev_wr;
    logic [31:0] prev_addr;
    logic        sequential;

    // Vector request decode. The full-width word index is kept so that
    // addresses beyond the store are rejected rather than aliased.
    assign idx       = mem_addr >> BYTE_SHIFT;
    assign vec_idx   = idx[ADDR_BITS-1:0];
    assign vec_busy  = mem_read | mem_write;
    assign vec_legal = ((mem_addr & ALIGN_MASK) == 32'd0) &&
                       (idx < DEPTH_W) &&
                       (mem_read ^ mem_write);
    assign rd_ok     = vec_legal & mem_read;
    assign wr_ok     = vec_legal & mem_write;
    assign mem_rdata = rd_ok ? mem[vec_idx] : '0;
    assign mem_err   = vec_busy & ~vec_legal;

    assign host_in_range = 32'(host_addr) < DEPTH_W;

    // An access continues a burst when the previous cycle was an access of
    // the same strobe pattern and this address is exactly one word further.
    assign sequential = vec_busy && prev_busy &&
                        (mem_read == prev_rd) && (mem_write == prev_wr) &&
                        (mem_addr == prev_addr + STRIDE);

    // Data store. No reset: contents survive rst, and a vector store that
    // coincides with rst is still committed. The host only reaches the
    // store in cycles without a vector access, so the two never collide.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[vec_idx] <= mem_wdata;
        end else if (host_go && !rst && host_we && host_in_range) begin
            mem[host_addr] <= host_wdata;
        end
    end

    // Host arbitration state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= H_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Host next-state logic. host_go marks the cycle in which the host
    // access is actually performed; it only fires when the vector side
    // is idle.
    always_comb begin
        next_state = state;
        host_go    = 1'b0;
        host_ack   = 1'b0;
        case (state)
            H_IDLE: begin
                if (host_req) begin
                    if (!vec_busy) begin
                        host_go    = 1'b1;
                        next_state = H_ACK;
                    end else begin
                        next_state = H_WAIT;
                    end
                end
            end
            H_WAIT: begin
                if (!vec_busy) begin
                    host_go    = 1'b1;
                    next_state = H_ACK;
                end
            end
            H_ACK: begin
                host_ack   = 1'b1;
                next_state = H_IDLE;
            end
            default: begin
                next_state = H_IDLE;
            end
        endcase
    end

    // Registered host read data; a reset abandons any pending read.
    always_ff @(posedge clk) begin
        if (rst) begin
            host_rdata <= '0;
        end else if (host_go && !host_we) begin
            host_rdata <= host_in_range ? mem[host_addr] : '0;
        end
    end

    // Statistics: saturating counters, sticky error flag and burst tracking.
    // The previous-access history is cleared by rst so the first access
    // afterwards always starts a new burst.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_count   <= '0;
            wr_count   <= '0;
            burst_len  <= '0;
            err_sticky <= 1'b0;
            prev_busy  <= 1'b0;
            prev_rd    <= 1'b0;
            prev_wr    <= 1'b0;
            prev_addr  <= '0;
        end else begin
            if (rd_ok && rd_count != CNT_MAX) begin
                rd_count <= rd_count + 1'b1;
            end
            if (wr_ok && wr_count != CNT_MAX) begin
                wr_count <= wr_count + 1'b1;
            end
            if (mem_err) begin
                err_sticky <= 1'b1;
            end
            if (!vec_busy) begin
                burst_len <= '0;
            end else if (sequential) begin
                if (burst_len != CNT_MAX) begin
                    burst_len <= burst_len + 1'b1;
                end
            end else begin
                burst_len <= {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
            prev_busy <= vec_busy;
            prev_rd   <= mem_read;
            prev_wr   <= mem_write;
            prev_addr <= mem_addr;
        end
    end

endmodule

// File: tb/tb_vector_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_vector_mem_responder
//
// Self-checking bench for vector_mem_responder. A behavioural reference
// model (word array, integer counters, host request bookkeeping) is
// advanced once per clock by the step task; scenario tasks drive directed
// and randomized traffic and compare DUT outputs against the model and
// against known constants.
// ---------------------------------------------------------------------------
module tb_vector_mem_responder;

    localparam int DEPTH   = 256;
    localparam int CNT_MAX = 65535;

    logic        clk;
    logic        rst;
    logic [31:0] mem_addr;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_err;
    logic        err_sticky;
    logic        host_req;
    logic        host_we;
    logic [7:0]  host_addr;
    logic [31:0] host_wdata;
    logic [31:0] host_rdata;
    logic        host_ack;
    logic [15:0] rd_count;
    logic [15:0] wr_count;
    logic [15:0] burst_len;

    vector_mem_responder #(
        .DATA_WIDTH(32),
        .DEPTH(DEPTH),
        .ADDR_BITS(8),
        .CNT_WIDTH(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .mem_addr(mem_addr),
        .mem_read(mem_read),
        .mem_write(mem_write),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_err(mem_err),
        .err_sticky(err_sticky),
        .host_req(host_req),
        .host_we(host_we),
        .host_addr(host_addr),
        .host_wdata(host_wdata),
        .host_rdata(host_rdata),
        .host_ack(host_ack),
        .rd_count(rd_count),
        .wr_count(wr_count),
        .burst_len(burst_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [31:0] ref_mem [DEPTH];
    int          ref_rd;
    int          ref_wr;
    int          ref_burst;
    bit          ref_sticky;
    bit          ref_prev_busy;
    bit          ref_prev_rd;
    bit          ref_prev_wr;
    logic [31:0] ref_prev_addr;
    bit          ref_h_pending;
    bit          ref_h_ack;
    logic [31:0] ref_hrdata;

    // Expected and observed values of the most recent step
    logic [31:0] exp_rdata;
    bit          exp_err;
    logic [31:0] obs_rdata;
    logic        obs_err;
    logic [15:0] obs_rd;
    logic [15:0] obs_wr;
    logic [15:0] obs_burst;
    logic        obs_sticky;
    logic        obs_ack;
    logic [31:0] obs_hrdata;

    // One clock cycle: apply inputs (at posedge+1), sample combinational
    // outputs at the falling edge, advance the model, then sample the
    // registered outputs just after the rising edge.
    task automatic step(input bit r, input bit w, input logic [31:0] a,
                        input logic [31:0] wd, input bit hq, input bit hw,
                        input logic [7:0] ha, input logic [31:0] hd,
                        input bit rs);
        bit busy;
        bit legal;
        bit seq;
        int idx;
        mem_read   = r;
        mem_write  = w;
        mem_addr   = a;
        mem_wdata  = wd;
        host_req   = hq;
        host_we    = hw;
        host_addr  = ha;
        host_wdata = hd;
        rst        = rs;
        busy  = r | w;
        legal = (a[1:0] == 2'b00) && ((a >> 2) < 32'(DEPTH)) && (r != w);
        idx   = legal ? int'(a >> 2) : 0;
        exp_rdata = (legal && r) ? ref_mem[idx] : 32'h0;
        exp_err   = busy && !legal;
        @(negedge clk);
        obs_rdata = mem_rdata;
        obs_err   = mem_err;
        if (legal && w) ref_mem[idx] = wd;
        seq = busy && ref_prev_busy && (ref_prev_rd == r) && (ref_prev_wr == w) &&
              (a == ref_prev_addr + 32'd4);
        if (rs) begin
            ref_rd = 0; ref_wr = 0; ref_burst = 0; ref_sticky = 0;
            ref_prev_busy = 0; ref_prev_rd = 0; ref_prev_wr = 0; ref_prev_addr = '0;
            ref_h_pending = 0; ref_h_ack = 0; ref_hrdata = '0;
        end else begin
            if (legal && r && ref_rd < CNT_MAX) ref_rd++;
            if (legal && w && ref_wr < CNT_MAX) ref_wr++;
            if (exp_err) ref_sticky = 1;
            if (!busy) ref_burst = 0;
            else if (seq) ref_burst = (ref_burst < CNT_MAX) ? ref_burst + 1 : ref_burst;
            else ref_burst = 1;
            ref_prev_busy = busy; ref_prev_rd = r; ref_prev_wr = w; ref_prev_addr = a;
            if (ref_h_ack) begin
                ref_h_ack = 0;
            end else if (ref_h_pending || hq) begin
                if (!busy) begin
                    if (hw) ref_mem[ha] = hd;
                    else ref_hrdata = ref_mem[ha];
                    ref_h_ack = 1;
                    ref_h_pending = 0;
                end else begin
                    ref_h_pending = 1;
                end
            end
        end
        @(posedge clk);
        #1;
        obs_rd     = rd_count;
        obs_wr     = wr_count;
        obs_burst  = burst_len;
        obs_sticky = err_sticky;
        obs_ack    = host_ack;
        obs_hrdata = host_rdata;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 32'h0, 32'h0, 0, 0, 8'h0, 32'h0, 0);
    endtask

    task automatic test_reset;
        @(posedge clk);
        #1;
        step(0, 0, 32'h0, 32'h0, 0, 0, 8'h0, 32'h0, 1);
        step(0, 0, 32'h0, 32'h0, 0, 0, 8'h0, 32'h0, 1);
        n_checks++;
        if (obs_hrdata !== 32'h0) begin n_errors++; $display("[TB] FAIL reset_host_rdata got %h want 0", obs_hrdata); end
        n_checks++;
        if (obs_ack !== 1'b0) begin n_errors++; $display("[TB] FAIL reset_host_ack got %b want 0", obs_ack); end
        n_checks++;
        if (obs_rd !== 16'h0 || obs_wr !== 16'h0) begin n_errors++; $display("[TB] FAIL reset_counts got rd=%0d wr=%0d want 0", obs_rd, obs_wr); end
        n_checks++;
        if (obs_burst !== 16'h0 || obs_sticky !== 1'b0) begin n_errors++; $display("[TB] FAIL reset_burst_sticky got burst=%0d sticky=%b want 0", obs_burst, obs_sticky); end
    endtask

    // Fill the whole store through the host port, then place the known
    // pattern in words 0..3 and read it back as a sequential vector burst.
    task automatic test_host_preload;
        logic [31:0] d;
        for (int i = 0; i < DEPTH; i++) begin
            d = (i < 4) ? 32'(8'h11 * (i + 1)) : $urandom;
            step(0, 0, 32'h0, 32'h0, 1, 1, 8'(i), d, 0);
            n_checks++;
            if (obs_ack !== 1'b1) begin n_errors++; $display("[TB] FAIL preload_ack idx=%0d got %b want 1", i, obs_ack); end
            step(0, 0, 32'h0, 32'h0, 0, 0, 8'h0, 32'h0, 0);
        end
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 32'(i * 4), 32'h0, 0, 0, 8'h0, 32'h0, 0);
            n_checks++;
            if (obs_rdata !== 32'(8'h11 * (i + 1))) begin n_errors++; $display("[TB] FAIL preload_read i=%0d got %h want %h", i, obs_rdata, 32'(8'h11 * (i + 1))); end
            n_checks++;
            if (obs_burst !== 16'(i + 1) || obs_rd !== 16'(i + 1)) begin n_errors++; $display("[TB] FAIL preload_burst i=%0d got burst=%0d rd=%0d want %0d", i, obs_burst, obs_rd, i + 1); end
        end
        idle(1);
    endtask

    task automatic test_store_load;
        step(0, 1, 32'h10, 32'hDEAD_BEEF, 0, 0, 8'h0, 32'h0, 0);
        step(1, 0, 32'h10, 32'h0, 0, 0, 8'h0, 32'h0, 0);
        n_checks++;
        if (obs_rdata !== 32'hDEAD_BEEF) begin n_errors++; $display("[TB] FAIL store_load got %h want deadbeef", obs_rdata); end
        n_checks++;
        if (obs_wr !== 16'd1 || obs_burst !== 16'd1) begin n_errors++; $display("[TB] FAIL store_load_stats got wr=%0d burst=%0d want 1 1", obs_wr, obs_burst); end
        idle(1);
    endtask

    task automatic test_errors;
        int rd_before;
        rd_before = ref_rd;
        step(1, 0, 32'h6, 32'h0, 0, 0, 8'h0, 32'h0, 0);
        n_checks++;
        if (obs_rdata !== 32'h0 || obs_err !== 1'b1) begin n_errors++; $display("[TB] FAIL misaligned got rdata=%h err=%b want 0 1", obs_rdata, obs_err); end
        n_checks++;
        if (obs_sticky !== 1'b1 || obs_rd !== 16'(rd_before)) begin n_errors++; $display("[TB] FAIL misaligned_stats got sticky=%b rd=%0d want 1 %0d", obs_sticky, obs_rd, rd_before); end
        step(0, 1, 32'(4 * DEPTH), 32'hBAD0_0001, 0, 0, 8'h0, 32'h0, 0);
        n_checks++;
        if (obs_err !== 1'b1) begin n_errors++; $display("[TB] FAIL out_of_range_err got %b want 1", obs_err); end
        step(1, 1, 32'h20, 32'hBAD0_0002, 0, 0, 8'h0, 32'h0, 0);
        n_checks++;
        if (obs_err !== 1'b1 || obs_rdata !== 32'h0) begin n_errors++; $display("[TB] FAIL both_strobes got err=%b rdata=%h want 1 0", obs_err, obs_rdata); end
        step(1, 0, 32'h0, 32'h0, 0, 0, 8'h0, 32'h0, 0);
        n_checks++;
        if (obs_rdata !== 32'h11) begin n_errors++; $display("[TB] FAIL oor_no_alias got %h want 11", obs_rdata); end
        step(1, 0, 32'h20, 32'h0, 0, 0, 8'h0, 32'h0, 0);
        n_checks++;
        if (obs_rdata !== exp_rdata || obs_rdata === 32'hBAD0_0002) begin n_errors++; $display("[TB] FAIL both_no_write got %h want %h", obs_rdata, exp_rdata); end
        step(1, 0, 32'(4 * DEPTH - 4), 32'h0, 0, 0, 8'h0, 32'h0, 0);
        n_checks++;
        if (obs_rdata !== exp_rdata || obs_err !== 1'b0) begin n_errors++; $display("[TB] FAIL last_word got rdata=%h err=%b want %h 0", obs_rdata, obs_err, exp_rdata); end
        idle(1);
    endtask

    // Host read issued alongside a four-element vector burst: no ack while
    // the vector side is busy, then exactly one ack after it goes idle.
    task automatic test_host_wait;
        int ack_at;
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 32'h40 + 32'(i * 4), 32'h0, 1, 0, 8'd5, 32'h0, 0);
            n_checks++;
            if (obs_ack !== 1'b0) begin n_errors++; $display("[TB] FAIL wait_no_ack i=%0d got %b want 0", i, obs_ack); end
        end
        ack_at = -1;
        for (int i = 0; i < 10 && ack_at < 0; i++) begin
            step(0, 0, 32'h0, 32'h0, 1, 0, 8'd5, 32'h0, 0);
            if (obs_ack === 1'b1) ack_at = i;
        end
        n_checks++;
        if (ack_at != 0) begin n_errors++; $display("[TB] FAIL wait_ack_time got %0d want 0", ack_at); end
        n_checks++;
        if (obs_hrdata !== ref_mem[5]) begin n_errors++; $display("[TB] FAIL wait_rdata got %h want %h", obs_hrdata, ref_mem[5]); end
        step(0, 0, 32'h0, 32'h0, 0, 0, 8'h0, 32'h0, 0);
        n_checks++;
        if (obs_ack !== 1'b0) begin n_errors++; $display("[TB] FAIL ack_single got %b want 0", obs_ack); end
        idle(1);
    endtask

    task automatic test_reset_in_wait;
        logic [31:0] old7;
        old7 = ref_mem[7];
        step(0, 1, 32'hC0, 32'hCAFE_F00D, 0, 0, 8'h0, 32'h0, 0);
        idle(1);
        step(0, 1, 32'h100, 32'hA000_0000, 1, 1, 8'd7, 32'h5555_AAAA, 0);
        step(0, 1, 32'h104, 32'hA000_0001, 1, 1, 8'd7, 32'h5555_AAAA, 0);
        step(0, 1, 32'h108, 32'hA000_0002, 1, 1, 8'd7, 32'h5555_AAAA, 1);
        n_checks++;
        if (obs_rd !== 16'h0 || obs_wr !== 16'h0 || obs_burst !== 16'h0) begin n_errors++; $display("[TB] FAIL rst_wait_counts got rd=%0d wr=%0d burst=%0d want 0", obs_rd, obs_wr, obs_burst); end
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 32'h0, 32'h0, 0, 0, 8'h0, 32'h0, 0);
            n_checks++;
            if (obs_ack !== 1'b0) begin n_errors++; $display("[TB] FAIL rst_wait_ack i=%0d got %b want 0", i, obs_ack); end
        end
        step(1, 0, 32'hC0, 32'h0, 0, 0, 8'h0, 32'h0, 0);
        n_checks++;
        if (obs_rdata !== 32'hCAFE_F00D) begin n_errors++; $display("[TB] FAIL rst_keep_data got %h want cafef00d", obs_rdata); end
        step(1, 0, 32'h108, 32'h0, 0, 0, 8'h0, 32'h0, 0);
        n_checks++;
        if (obs_rdata !== 32'hA000_0002) begin n_errors++; $display("[TB] FAIL rst_cycle_write got %h want a0000002", obs_rdata); end
        step(1, 0, 32'h1C, 32'h0, 0, 0, 8'h0, 32'h0, 0);
        n_checks++;
        if (obs_rdata !== old7) begin n_errors++; $display("[TB] FAIL rst_host_abandon got %h want %h", obs_rdata, old7); end
        idle(1);
    endtask

    // Randomized mixed traffic: bursts, legal/illegal vector accesses and
    // host requests, every output compared with the model each cycle.
    task automatic test_random;
        bit          r, w, hq, hw, h_active, last_ack;
        logic [31:0] a, la;
        logic [7:0]  ha;
        logic [31:0] hd;
        bit          lr, lw;
        int          mode;
        h_active = 0; last_ack = 0; hq = 0; hw = 0; ha = '0; hd = '0;
        lr = 0; lw = 0; la = '0;
        for (int c = 0; c < 600; c++) begin
            mode = int'($urandom_range(0, 9));
            r = $urandom_range(0, 1) == 1;
            w = !r;
            a = 32'($urandom_range(0, DEPTH - 1)) * 32'd4;
            case (mode)
                0, 1: begin r = 0; w = 0; end
                2, 3, 4: if (lr || lw) begin r = lr; w = lw; a = la + 32'd4; end
                7: a = a + 32'($urandom_range(1, 3));
                8: a = 32'(4 * DEPTH) + 32'($urandom_range(0, 1000)) * 32'd4;
                9: begin r = 1; w = 1; end
                default: ;
            endcase
            if (!h_active && !last_ack && $urandom_range(0, 7) == 0) begin
                h_active = 1;
                hw = $urandom_range(0, 1) == 1;
                ha = 8'($urandom_range(0, DEPTH - 1));
                hd = $urandom;
            end
            hq = h_active;
            step(r, w, a, $urandom, hq, hw, ha, hd, 0);
            n_checks++;
            if (obs_rdata !== exp_rdata || obs_err !== exp_err) begin n_errors++; $display("[TB] FAIL rand_comb c=%0d got rdata=%h err=%b want %h %b", c, obs_rdata, obs_err, exp_rdata, exp_err); end
            n_checks++;
            if (obs_rd !== 16'(ref_rd) || obs_wr !== 16'(ref_wr)) begin n_errors++; $display("[TB] FAIL rand_counts c=%0d got rd=%0d wr=%0d want %0d %0d", c, obs_rd, obs_wr, ref_rd, ref_wr); end
            n_checks++;
            if (obs_burst !== 16'(ref_burst) || obs_sticky !== ref_sticky) begin n_errors++; $display("[TB] FAIL rand_burst c=%0d got burst=%0d sticky=%b want %0d %b", c, obs_burst, obs_sticky, ref_burst, ref_sticky); end
            n_checks++;
            if (obs_ack !== ref_h_ack || obs_hrdata !== ref_hrdata) begin n_errors++; $display("[TB] FAIL rand_host c=%0d got ack=%b rdata=%h want %b %h", c, obs_ack, obs_hrdata, ref_h_ack, ref_hrdata); end
            last_ack = obs_ack;
            if (obs_ack === 1'b1) h_active = 0;
            lr = r; lw = w; la = a;
        end
        idle(2);
    endtask

    initial begin
        rst = 1'b0; mem_addr = '0; mem_read = 0; mem_write = 0; mem_wdata = '0;
        host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        ref_rd = 0; ref_wr = 0; ref_burst = 0; ref_sticky = 0;
        ref_prev_busy = 0; ref_prev_rd = 0; ref_prev_wr = 0; ref_prev_addr = '0;
        ref_h_pending = 0; ref_h_ack = 0; ref_hrdata = '0;
        test_reset;
        test_host_preload;
        test_store_load;
        test_errors;
        test_host_wait;
        test_reset_in_wait;
        test_random;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
